instr_fetch_seq: RTL and testbench

INSTR_FETCH_SEQ -- requirements
Module: instr_fetch_seq

---
 rtl/instr_fetch_seq.sv | 112 +++++++++++
 tb/tb_instr_fetch_seq.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: assembles a 16-bit instruction from two byte reads (low then high) and holds it for downstream.
// Latency: Run rising in IDLE gives Valid after the third rising edge; back-to-back throughput is one instruction per 3 cycles.
// Backpressure: Ready=0 parks the sequencer in HOLD with IROut/Valid/PC frozen; Flush overrides Ready and any partial fetch.
//
// Ports: Clock/Reset (sync, active-high); Run, Flush, FlushAddr, Ready control inputs;
//        Address/Mem_CS/Mem_WR/MemData form the read-only memory port; IR_LH marks the byte being loaded;
//        IROut/Valid present the instruction; Busy is high outside IDLE; InstrCount counts accepted instructions.
// Optional feature: define INSTR_FETCH_COUNT_EN to build the accepted-instruction counter; otherwise InstrCount is 0.
module instr_fetch_seq (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Run,
    input  logic        Flush,
    input  logic [7:0]  FlushAddr,
    input  logic [7:0]  MemData,
    input  logic        Ready,
    output logic [7:0]  Address,
    output logic        Mem_CS,
    output logic        Mem_WR,
    output logic        IR_LH,
    output logic [15:0] IROut,
    output logic        Valid,
    output logic        Busy,
    output logic [15:0] InstrCount
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH_L = 2'd1,
        FETCH_H = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic        handshake;

    // Flush wins over Ready, so a flushed HOLD cycle is never an accepted instruction.
    assign handshake = (state_q == HOLD) && Ready && !Flush;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            pc_q    <= 8'h00;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        if (Flush) begin
            // Redirect discards whatever half-built instruction is in flight.
            pc_d    = FlushAddr;
            state_d = Run ? FETCH_L : IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (Run) state_d = FETCH_L;
                end
                FETCH_L: begin
                    ir_d[7:0] = MemData;
                    pc_d      = pc_q + 8'd1;   // 8-bit add wraps 0xFF -> 0x00
                    state_d   = FETCH_H;
                end
                FETCH_H: begin
                    ir_d[15:8] = MemData;
                    pc_d       = pc_q + 8'd1;
                    state_d    = HOLD;
                end
                HOLD: begin
                    if (Ready) state_d = Run ? FETCH_L : IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef INSTR_FETCH_COUNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (handshake) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge Clock) begin
        if (Reset) cnt_q <= 16'h0000;
        else       cnt_q <= cnt_d;
    end

    assign InstrCount = cnt_q;
`else
    assign InstrCount = 16'h0000;
`endif

    // All outputs decode registered state only; Ready never reaches Address combinationally.
    assign Address = pc_q;
    assign Mem_CS  = !((state_q == FETCH_L) || (state_q == FETCH_H));
    assign Mem_WR  = 1'b0;
    assign IR_LH   = (state_q == FETCH_H);
    assign IROut   = ir_q;
    assign Valid   = (state_q == HOLD);
    assign Busy    = (state_q != IDLE);

endmodule

// File: tb/tb_instr_fetch_seq.sv
module tb_instr_fetch_seq;

    logic        Clock = 1'b0;
    logic        Reset, Run, Flush, Ready;
    logic [7:0]  FlushAddr;
    logic [7:0]  MemData;
    logic [7:0]  Address;
    logic        Mem_CS, Mem_WR, IR_LH, Valid, Busy;
    logic [15:0] IROut, InstrCount;

    logic [7:0] mem [256];

    int n_checks = 0;
    int n_errors = 0;

    instr_fetch_seq dut (
        .Clock(Clock), .Reset(Reset), .Run(Run), .Flush(Flush),
        .FlushAddr(FlushAddr), .MemData(MemData), .Ready(Ready),
        .Address(Address), .Mem_CS(Mem_CS), .Mem_WR(Mem_WR), .IR_LH(IR_LH),
        .IROut(IROut), .Valid(Valid), .Busy(Busy), .InstrCount(InstrCount)
    );

    always #5 Clock = ~Clock;

    assign MemData = mem[Address];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; inputs are driven and outputs sampled at the falling edge.
    task automatic step();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    function automatic logic [15:0] exp_cnt(input logic [15:0] n);
`ifdef INSTR_FETCH_COUNT_EN
        return n;
`else
        return 16'h0000;
`endif
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h34; mem[8'h01] = 8'h12;
        mem[8'h02] = 8'h78; mem[8'h03] = 8'h56;
        mem[8'hFF] = 8'hAA;
        mem[8'h40] = 8'hEF; mem[8'h41] = 8'hBE;

        Reset = 1'b1; Run = 1'b1; Flush = 1'b1; FlushAddr = 8'h99; Ready = 1'b0;
        @(negedge Clock);
        step();
        // Reset overrides Run and Flush
        check("rst_addr",  Address, 8'h00);
        check("rst_ir",    IROut, 16'h0000);
        check("rst_valid", Valid, 1'b0);
        check("rst_cs",    Mem_CS, 1'b1);
        check("rst_busy",  Busy, 1'b0);
        check("rst_wr",    Mem_WR, 1'b0);
        check("rst_cnt",   InstrCount, 16'h0000);

        // First fetch: 0x1234 from address 0/1
        Reset = 1'b0; Flush = 1'b0; Run = 1'b1; Ready = 1'b1;
        step();
        check("e1_cs",   Mem_CS, 1'b0);
        check("e1_lh",   IR_LH, 1'b0);
        check("e1_addr", Address, 8'h00);
        check("e1_valid", Valid, 1'b0);
        step();
        check("e2_lh",   IR_LH, 1'b1);
        check("e2_addr", Address, 8'h01);
        check("e2_ir",   IROut, 16'h0034);
        step();
        check("e3_valid", Valid, 1'b1);
        check("e3_ir",    IROut, 16'h1234);
        check("e3_addr",  Address, 8'h02);
        check("e3_cs",    Mem_CS, 1'b1);
        step(); // handshake, Run=1 -> FETCH_L
        check("hs1_valid", Valid, 1'b0);
        check("hs1_cs",    Mem_CS, 1'b0);
        check("hs1_lh",    IR_LH, 1'b0);
        check("hs1_cnt",   InstrCount, exp_cnt(16'd1));

        // Backpressure: second instruction 0x5678 held for 5 cycles
        Ready = 1'b0;
        step(); step();
        check("hold_valid0", Valid, 1'b1);
        check("hold_ir0",    IROut, 16'h5678);
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_valid", Valid, 1'b1);
            check("hold_ir",    IROut, 16'h5678);
            check("hold_cs",    Mem_CS, 1'b1);
            check("hold_pc",    Address, 8'h04);
        end
        check("hold_cnt", InstrCount, exp_cnt(16'd1));
        Ready = 1'b1;
        step();
        check("rel_valid", Valid, 1'b0);
        check("rel_cs",    Mem_CS, 1'b0);
        check("rel_lh",    IR_LH, 1'b0);
        check("rel_cnt",   InstrCount, exp_cnt(16'd2));

        // PC wrap: redirect to 0xFF, expect 0x55AA and PC=0x01
        mem[8'h00] = 8'h55;
        Flush = 1'b1; FlushAddr = 8'hFF; Ready = 1'b0;
        step();
        check("fl_addr",  Address, 8'hFF);
        check("fl_cs",    Mem_CS, 1'b0);
        Flush = 1'b0;
        step();
        check("wrap_mid", Address, 8'h00);
        step();
        check("wrap_ir",    IROut, 16'h55AA);
        check("wrap_addr",  Address, 8'h01);
        check("wrap_valid", Valid, 1'b1);
        Ready = 1'b1;
        step(); // handshake -> FETCH_L @0x01
        check("wrap_cnt", InstrCount, exp_cnt(16'd3));
        step(); // FETCH_H @0x02
        check("pre_fl_lh", IR_LH, 1'b1);

        // Flush during FETCH_H discards the partial instruction
        Flush = 1'b1; FlushAddr = 8'h40;
        step();
        Flush = 1'b0;
        check("flh_valid", Valid, 1'b0);
        check("flh_addr",  Address, 8'h40);
        check("flh_lh",    IR_LH, 1'b0);
        check("flh_cnt",   InstrCount, exp_cnt(16'd3));

        // Run=0 in FETCH_L: instruction still completes, then IDLE
        Run = 1'b0; Ready = 1'b0;
        step();
        check("r0_busy", Busy, 1'b1);
        check("r0_lh",   IR_LH, 1'b1);
        step();
        check("r0_valid", Valid, 1'b1);
        check("r0_ir",    IROut, 16'hBEEF);
        Ready = 1'b1;
        step();
        check("r0_idle_busy",  Busy, 1'b0);
        check("r0_idle_valid", Valid, 1'b0);
        check("r0_idle_cs",    Mem_CS, 1'b1);
        check("r0_idle_addr",  Address, 8'h42);
        check("cnt4",          InstrCount, exp_cnt(16'd4));
        step();
        check("idle_stay", Busy, 1'b0);

        // Reset mid-fetch discards state
        Run = 1'b1;
        step();
        check("pre_rst_busy", Busy, 1'b1);
        Reset = 1'b1; Flush = 1'b1; FlushAddr = 8'h77;
        step();
        check("mrst_addr", Address, 8'h00);
        check("mrst_busy", Busy, 1'b0);
        check("mrst_ir",   IROut, 16'h0000);
        check("mrst_cnt",  InstrCount, 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
